// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response handshake of the load/store unit plus its memory port.
// The slave side is the LSU; the master side is the core and data memory together.
interface mem_lsu_if;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_in;
  logic        mem_memwr;
  logic [31:0] mem_out;

  modport master (
    output req, op, addr, wdata, mem_out,
    input  ready, done, rdata, fault, mem_raddr, mem_waddr, mem_in, mem_memwr
  );

  modport slave (
    input  req, op, addr, wdata, mem_out,
    output ready, done, rdata, fault, mem_raddr, mem_waddr, mem_in, mem_memwr
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: one-at-a-time load/store initiator; byte/halfword stores are read-modify-write.
// Optional LSU_ALIGN_CHECK_EN: misaligned halfword/word accesses are rejected with fault.
//
// state | meaning
// IDLE  | ready, waiting for a request
// RD    | read address driven from the registered addr
// CAP   | memory data valid: capture load result or build store merge word
// WR    | one-cycle memory write
// DONE  | completion pulse (fault qualifies it)
module mem_lsu #(
  parameter int unsigned MEM_BYTES = 1376
) (
  input logic       clk,
  input logic       rst,
  mem_lsu_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  localparam logic [3:0]  OP_SW = 4'b1010;
  localparam logic [32:0] LAST  = 33'(MEM_BYTES - 1);

  state_t      state, state_n;
  logic [3:0]  op_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
  logic        fault_q;

  logic        accept, reject, op_legal, out_of_range, misaligned;
  logic [32:0] end_addr;
  logic [31:0] load_val, merge_val;

  assign accept       = bus.req && (state == IDLE);
  assign end_addr     = {1'b0, bus.addr} + 33'd3;
  assign out_of_range = end_addr > LAST;

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b1000, 4'b1001, 4'b1010: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((bus.op[1:0] == 2'b01) && bus.addr[0]) ||
                      ((bus.op[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign reject = !op_legal || out_of_range || misaligned;

  // op[2] marks the zero-extending loads; op[1:0] encodes the access size
  always_comb begin
    load_val = bus.mem_out;
    case (op_q[1:0])
      2'b00:   load_val = {{24{bus.mem_out[7] & ~op_q[2]}}, bus.mem_out[7:0]};
      2'b01:   load_val = {{16{bus.mem_out[15] & ~op_q[2]}}, bus.mem_out[15:0]};
      default: load_val = bus.mem_out;
    endcase
  end

  always_comb begin
    merge_val = {bus.mem_out[31:8], wdata_q[7:0]};
    if (op_q[0]) merge_val = {bus.mem_out[31:16], wdata_q[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) begin
        if (reject)                state_n = DONE;
        else if (bus.op == OP_SW)  state_n = WR;
        else                       state_n = RD;
      end
      RD:      state_n = CAP;
      CAP:     state_n = op_q[3] ? WR : DONE;
      WR:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.op;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        fault_q <= reject;
        if (reject) rdata_q <= '0;
      end
      if (state == DONE) fault_q <= 1'b0;
      if (state == CAP) begin
        if (op_q[3]) merge_q <= merge_val;
        else         rdata_q <= load_val;
      end
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.fault     = fault_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_raddr = addr_q;
  assign bus.mem_waddr = addr_q;
  assign bus.mem_in    = (op_q == OP_SW) ? wdata_q : merge_q;
  assign bus.mem_memwr = (state == WR);

endmodule
